// File: rtl/pcie_dma_desc_mux.sv
// Round-robin merge of PORTS descriptor streams onto one DMA descriptor interface,
// with the source port encoded in the tag MSBs and a registered status demux back to the ports.
module pcie_dma_desc_mux #(
  parameter int PORTS           = 4,
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int LEN_WIDTH       = 20,
  parameter int S_TAG_WIDTH     = 6,
  parameter int M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PORTS*PCIE_ADDR_WIDTH-1:0]   s_axis_desc_pcie_addr,
  input  logic [PORTS*AXI_ADDR_WIDTH-1:0]    s_axis_desc_axi_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]         s_axis_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]       s_axis_desc_tag,
  input  logic [PORTS-1:0]                   s_axis_desc_valid,
  output logic [PORTS-1:0]                   s_axis_desc_ready,
  output logic [PCIE_ADDR_WIDTH-1:0]         m_axis_desc_pcie_addr,
  output logic [AXI_ADDR_WIDTH-1:0]          m_axis_desc_axi_addr,
  output logic [LEN_WIDTH-1:0]               m_axis_desc_len,
  output logic [M_TAG_WIDTH-1:0]             m_axis_desc_tag,
  output logic                               m_axis_desc_valid,
  input  logic                               m_axis_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]             s_axis_desc_status_tag,
  input  logic                               s_axis_desc_status_valid,
  output logic [S_TAG_WIDTH-1:0]             m_axis_desc_status_tag,
  output logic [PORTS-1:0]                   m_axis_desc_status_valid
);

  localparam int PW = $clog2(PORTS);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    idx;
  logic             grant_vld;
  logic             load;
  logic             accept;
  logic [PORTS-1:0] status_dec;
  logic [M_TAG_WIDTH-S_TAG_WIDTH-1:0] status_port;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % PORTS);
      if (s_axis_desc_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign load   = !m_axis_desc_valid || m_axis_desc_ready;
  assign accept = grant_vld && load && rst_n;

  always_comb begin
    s_axis_desc_ready = '0;
    s_axis_desc_ready[grant_idx] = accept;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr                   <= '0;
      m_axis_desc_valid     <= 1'b0;
      m_axis_desc_pcie_addr <= '0;
      m_axis_desc_axi_addr  <= '0;
      m_axis_desc_len       <= '0;
      m_axis_desc_tag       <= '0;
    end else if (accept) begin
      ptr                   <= (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
      m_axis_desc_valid     <= 1'b1;
      m_axis_desc_pcie_addr <= s_axis_desc_pcie_addr[int'(grant_idx)*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
      m_axis_desc_axi_addr  <= s_axis_desc_axi_addr[int'(grant_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      m_axis_desc_len       <= s_axis_desc_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
      m_axis_desc_tag       <= M_TAG_WIDTH'({grant_idx, s_axis_desc_tag[int'(grant_idx)*S_TAG_WIDTH +: S_TAG_WIDTH]});
    end else if (m_axis_desc_ready) begin
      m_axis_desc_valid     <= 1'b0;
    end
  end

  // Port indices with no matching port decode to no strobe at all.
  assign status_port = s_axis_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];

  always_comb begin
    status_dec = '0;
    for (int i = 0; i < PORTS; i++) begin
      status_dec[i] = s_axis_desc_status_valid && (int'(status_port) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_desc_status_valid <= '0;
      m_axis_desc_status_tag   <= '0;
    end else begin
      m_axis_desc_status_valid <= status_dec;
      if (s_axis_desc_status_valid) begin
        m_axis_desc_status_tag <= s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pcie_dma_desc_mux.sv
// Directed stimulus with queued expectations; a negedge monitor pops and compares on every output handshake/strobe.
module tb_pcie_dma_desc_mux;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] s_pcie;
  logic [255:0] s_axi;
  logic [79:0]  s_len;
  logic [23:0]  s_tag;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [63:0]  m_pcie;
  logic [63:0]  m_axi;
  logic [19:0]  m_len;
  logic [7:0]   m_tag;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   st_in_tag;
  logic         st_in_valid;
  logic [5:0]   st_out_tag;
  logic [3:0]   st_out_valid;

  typedef struct packed {
    logic [63:0] pcie;
    logic [63:0] axi;
    logic [19:0] len;
    logic [7:0]  tag;
  } desc_t;

  typedef struct packed {
    logic [3:0] vld;
    logic [5:0] tag;
  } status_t;

  desc_t   desc_q[$];
  status_t status_q[$];
  int      errors = 0;
  int      checks = 0;

  always #5 clk = ~clk;

  pcie_dma_desc_mux dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .s_axis_desc_pcie_addr    (s_pcie),
    .s_axis_desc_axi_addr     (s_axi),
    .s_axis_desc_len          (s_len),
    .s_axis_desc_tag          (s_tag),
    .s_axis_desc_valid        (s_valid),
    .s_axis_desc_ready        (s_ready),
    .m_axis_desc_pcie_addr    (m_pcie),
    .m_axis_desc_axi_addr     (m_axi),
    .m_axis_desc_len          (m_len),
    .m_axis_desc_tag          (m_tag),
    .m_axis_desc_valid        (m_valid),
    .m_axis_desc_ready        (m_ready),
    .s_axis_desc_status_tag   (st_in_tag),
    .s_axis_desc_status_valid (st_in_valid),
    .m_axis_desc_status_tag   (st_out_tag),
    .m_axis_desc_status_valid (st_out_valid)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-port descriptor contents used in the multi-port tests.
  function automatic desc_t port_desc(input int p);
    desc_t d;
    d.pcie = 64'h0000_1000_0000_0000 + 64'(p) * 64'h1000;
    d.axi  = 64'h8000_0000 + 64'(p);
    d.len  = 20'(100 + p);
    d.tag  = {2'(p), 6'(6'h10 + p)};
    return d;
  endfunction

  task automatic set_port(input int p, input desc_t d);
    s_pcie[p*64 +: 64] = d.pcie;
    s_axi[p*64 +: 64]  = d.axi;
    s_len[p*20 +: 20]  = d.len;
    s_tag[p*6 +: 6]    = d.tag[5:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        if (desc_q.size() == 0) begin
          chk("desc_unexpected", {56'd0, m_tag}, 64'hFFFF);
        end else begin
          desc_t e;
          e = desc_q.pop_front();
          chk("desc_tag", {56'd0, m_tag}, {56'd0, e.tag});
          chk("desc_pcie", m_pcie, e.pcie);
          chk("desc_axi", m_axi, e.axi);
          chk("desc_len", {44'd0, m_len}, {44'd0, e.len});
        end
      end
      if (st_out_valid != 4'b0) begin
        if (status_q.size() == 0) begin
          chk("status_unexpected", {60'd0, st_out_valid}, 64'h0);
        end else begin
          status_t s;
          s = status_q.pop_front();
          chk("status_valid", {60'd0, st_out_valid}, {60'd0, s.vld});
          chk("status_tag", {58'd0, st_out_tag}, {58'd0, s.tag});
        end
      end
    end
  end

  initial begin
    desc_t lit;
    rst_n = 1'b0; s_pcie = '0; s_axi = '0; s_len = '0; s_tag = '0;
    s_valid = 4'hF; m_ready = 1'b1; st_in_tag = '0; st_in_valid = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_status_valid", {60'd0, st_out_valid}, 64'd0);
    chk("rst_s_ready", {60'd0, s_ready}, 64'd0);
    chk("rst_m_tag", {56'd0, m_tag}, 64'd0);
    chk("rst_m_pcie", m_pcie, 64'd0);
    chk("rst_status_tag", {58'd0, st_out_tag}, 64'd0);
    tick();
    rst_n = 1'b1;

    // Fairness: all ports valid, grant order 0,1,2,3,0,1,2,3
    for (int p = 0; p < 4; p++) set_port(p, port_desc(p));
    s_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_ready", {60'd0, s_ready}, 64'(4'b0001 << (c % 4)));
      desc_q.push_back(port_desc(c % 4));
      tick();
    end
    s_valid = 4'h0;

    // Single port 2: tag 5 becomes 0x85
    lit.pcie = 64'h1000; lit.axi = 64'h2000; lit.len = 20'd64; lit.tag = 8'h85;
    set_port(2, lit);
    s_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", {60'd0, s_ready}, 64'b0100);
    desc_q.push_back(lit);
    tick();
    s_valid = 4'h0;
    @(negedge clk);
    chk("single_ready_drop", {60'd0, s_ready}, 64'd0);
    tick();

    // Backpressure: port 3 held for 5 stalled cycles, then port 0 next
    m_ready = 1'b0;
    set_port(3, port_desc(3));
    s_valid = 4'b1000;
    @(negedge clk);
    chk("bp_first_ready", {60'd0, s_ready}, 64'b1000);
    desc_q.push_back(port_desc(3));
    tick();
    s_valid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_ready", {60'd0, s_ready}, 64'd0);
      chk("bp_valid", {63'd0, m_valid}, 64'd1);
      chk("bp_tag", {56'd0, m_tag}, {56'd0, port_desc(3).tag});
      chk("bp_pcie", m_pcie, port_desc(3).pcie);
      tick();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {60'd0, s_ready}, 64'b0001);
    desc_q.push_back(port_desc(0));
    tick();
    s_valid = 4'h0;
    @(negedge clk);
    tick();

    // Status routing
    st_in_valid = 1'b1;
    st_in_tag = 8'hC3; status_q.push_back('{vld: 4'b1000, tag: 6'h03});
    tick();
    st_in_tag = 8'h01; status_q.push_back('{vld: 4'b0001, tag: 6'h01});
    tick();
    st_in_tag = 8'h7F; status_q.push_back('{vld: 4'b0010, tag: 6'h3F});
    tick();
    st_in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("status_idle_valid", {60'd0, st_out_valid}, 64'd0);
    chk("status_hold_tag", {58'd0, st_out_tag}, 64'h3F);
    tick();

    // Concurrent accept (port 1, ptr=1) and status strobe
    set_port(1, port_desc(1));
    s_valid = 4'b0010;
    st_in_valid = 1'b1; st_in_tag = 8'h45;
    status_q.push_back('{vld: 4'b0010, tag: 6'h05});
    @(negedge clk);
    chk("conc_ready", {60'd0, s_ready}, 64'b0010);
    desc_q.push_back(port_desc(1));
    tick();
    s_valid = 4'h0; st_in_valid = 1'b0;
    tick();

    // Reset mid-operation: held descriptor and pending status are discarded
    m_ready = 1'b0;
    s_valid = 4'b0100;
    tick();
    s_valid = 4'h0;
    st_in_valid = 1'b1; st_in_tag = 8'h82;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_held_valid", {63'd0, m_valid}, 64'd1);
    tick();
    rst_n = 1'b1; st_in_valid = 1'b0; m_ready = 1'b1;
    s_valid = 4'hF;
    @(negedge clk);
    chk("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("midrst_status_valid", {60'd0, st_out_valid}, 64'd0);
    chk("midrst_first_grant", {60'd0, s_ready}, 64'b0001);
    desc_q.push_back(port_desc(0));
    tick();
    s_valid = 4'h0;
    repeat (4) tick();

    chk("desc_q_drained", 64'(desc_q.size()), 64'd0);
    chk("status_q_drained", 64'(status_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
